// File: rtl/cmd_scheduler_pkg.sv
// Shared types for the command scheduler: user command encoding, FSM states
// and the executor one-hot helper.
package tetris;

    typedef enum logic [1:0] {
        eCmdRotate = 2'd0,
        eCmdLeft   = 2'd1,
        eCmdRight  = 2'd2,
        eCmdDown   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eIssue = 2'd1,
        eBusy  = 2'd2
    } sched_state_e;

    function automatic logic [3:0] exe_onehot(input logic [1:0] idx);
        exe_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/cmd_scheduler_fifo.sv
// Two-entry command FIFO feeding the scheduler; pushes are dropped when full
// and pops are dropped when empty.
module cmd_fifo
    import tetris::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic push_i,
    input  cmd_e data_i,
    input  logic pop_i,
    output cmd_e data_o,
    output logic full_o,
    output logic empty_o
);

    cmd_e       mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       do_push_s;
    logic       do_pop_s;

    assign full_o    = (count_r == 2'd2);
    assign empty_o   = (count_r == 2'd0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_r[rd_ptr_r];

    // Storage and read/write pointers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_r[0] <= eCmdRotate;
            mem_r[1] <= eCmdRotate;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Occupancy; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Dispatches queued user commands and gravity ticks to four executors, one at a
// time. Optional gravity path enabled by macro CMD_SCHEDULER_GRAVITY_EN.
module cmd_scheduler
    import tetris::*;
#(
    parameter int width_p   = 16,
    parameter int height_p  = 32,
    parameter int timeout_p = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              cmd_v_i,
    input  cmd_e                              cmd_i,
    output logic                              cmd_ready_o,
    input  logic                              tick_i,
    output logic [3:0]                        exe_v_o,
    input  logic [3:0]                        exe_ready_i,
    input  logic [3:0][$clog2(width_p):0]     exe_mm_x_i,
    input  logic [3:0][$clog2(height_p):0]    exe_mm_y_i,
    input  logic [3:0][4:0]                   exe_rom_addr_i,
    output logic [$clog2(width_p):0]          mm_addr_r_x_o,
    output logic [$clog2(height_p):0]         mm_addr_r_y_o,
    output logic [4:0]                        rom_read_addr_o,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam logic [5:0] timeout_lp = 6'(timeout_p);

    sched_state_e state_r;
    sched_state_e state_s;
    logic [1:0]   grant_r;
    logic [1:0]   tgt_s;
    logic         tgt_grav_s;
    logic         req_s;
    logic         grav_src_r;
    logic         grav_pend_r;
    logic         pop_s;
    logic         clr_grav_s;
    logic         timeout_s;
    logic [5:0]   cnt_r;
    logic         err_r;
    logic [3:0]   exe_v_r;
    cmd_e         fifo_head_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic         push_s;

    assign push_s      = cmd_v_i && !fifo_full_s;
    assign cmd_ready_o = !fifo_full_s;

    cmd_fifo u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .data_i  (cmd_i),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Pending-request select: gravity outranks the FIFO head and targets the down executor
    always_comb begin
        req_s      = 1'b0;
        tgt_s      = 2'd0;
        tgt_grav_s = 1'b0;
        if (grav_pend_r) begin
            req_s      = 1'b1;
            tgt_s      = 2'd3;
            tgt_grav_s = 1'b1;
        end else if (!fifo_empty_s) begin
            req_s = 1'b1;
            tgt_s = fifo_head_s;
        end else begin
            req_s = 1'b0;
        end
    end

    // FSM next state; a blocked request waits in eIDLE rather than skipping ahead
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        clr_grav_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            eIDLE: begin
                if (req_s && exe_ready_i[tgt_s]) state_s = eIssue;
                else                             state_s = eIDLE;
            end
            eIssue: begin
                state_s    = eBusy;
                pop_s      = !grav_src_r;
                clr_grav_s = grav_src_r;
            end
            eBusy: begin
                if (exe_ready_i[grant_r]) begin
                    state_s = eIDLE;
                end else if ((cnt_r + 6'd1) == timeout_lp) begin
                    state_s   = eIDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = eBusy;
                end
            end
            default: state_s = eIDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= eIDLE;
        else         state_r <= state_s;
    end

    // Grant capture, start pulse, busy-cycle counter and sticky timeout error
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_r    <= 2'd0;
            grav_src_r <= 1'b0;
            exe_v_r    <= 4'd0;
            cnt_r      <= 6'd0;
            err_r      <= 1'b0;
        end else begin
            if ((state_r == eIDLE) && (state_s == eIssue)) begin
                grant_r    <= tgt_s;
                grav_src_r <= tgt_grav_s;
                exe_v_r    <= exe_onehot(tgt_s);
            end else begin
                exe_v_r <= 4'd0;
            end
            cnt_r <= (state_r == eBusy) ? (cnt_r + 6'd1) : 6'd0;
            err_r <= err_r | timeout_s;
        end
    end

`ifdef CMD_SCHEDULER_GRAVITY_EN
    // Coalescing gravity request; a new tick beats the clear from its own dispatch
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)         grav_pend_r <= 1'b0;
        else if (tick_i)     grav_pend_r <= 1'b1;
        else if (clr_grav_s) grav_pend_r <= 1'b0;
        else                 grav_pend_r <= grav_pend_r;
    end
`else
    logic [1:0] gravity_unused_s;
    assign gravity_unused_s = {tick_i, clr_grav_s};
    assign grav_pend_r      = 1'b0;
`endif

    assign exe_v_o         = exe_v_r;
    assign busy_o          = (state_r != eIDLE);
    assign err_o           = err_r;
    assign mm_addr_r_x_o   = exe_mm_x_i[grant_r];
    assign mm_addr_r_y_o   = exe_mm_y_i[grant_r];
    assign rom_read_addr_o = exe_rom_addr_i[grant_r];

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cmd_scheduler;
    import tetris::*;

    localparam int width_p   = 16;
    localparam int height_p  = 32;
    localparam int timeout_p = 32;
`ifdef CMD_SCHEDULER_GRAVITY_EN
    localparam bit grav_en = 1'b1;
`else
    localparam bit grav_en = 1'b0;
`endif

    logic            clk_i;
    logic            reset_i;
    logic            cmd_v_i;
    cmd_e            cmd_i;
    logic            cmd_ready_o;
    logic            tick_i;
    logic [3:0]      exe_v_o;
    logic [3:0]      exe_ready_i;
    logic [3:0][4:0] exe_mm_x_i;
    logic [3:0][5:0] exe_mm_y_i;
    logic [3:0][4:0] exe_rom_addr_i;
    logic [4:0]      mm_addr_r_x_o;
    logic [5:0]      mm_addr_r_y_o;
    logic [4:0]      rom_read_addr_o;
    logic            busy_o;
    logic            err_o;

    cmd_scheduler #(.width_p(width_p), .height_p(height_p), .timeout_p(timeout_p)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_i(cmd_i),
        .cmd_ready_o(cmd_ready_o), .tick_i(tick_i), .exe_v_o(exe_v_o),
        .exe_ready_i(exe_ready_i), .exe_mm_x_i(exe_mm_x_i), .exe_mm_y_i(exe_mm_y_i),
        .exe_rom_addr_i(exe_rom_addr_i), .mm_addr_r_x_o(mm_addr_r_x_o),
        .mm_addr_r_y_o(mm_addr_r_y_o), .rom_read_addr_o(rom_read_addr_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int         checks;
    int         errors;
    logic [3:0] pulses [$];

    // Reference model: pending commands as a queue, scheduler as idle/issue/busy phase
    int q [$];
    int m_phase;
    int m_cnt;
    int m_grant;
    bit m_from_grav;
    bit m_pend;
    bit m_err;

    function automatic void model_reset();
        q.delete();
        m_phase     = 0;
        m_cnt       = 0;
        m_grant     = 0;
        m_from_grav = 1'b0;
        m_pend      = 1'b0;
        m_err       = 1'b0;
    endfunction

    function automatic void model_edge();
        bit accept;
        bit clear;
        bit have;
        int tgt;
        accept = cmd_v_i && (q.size() < 2);
        clear  = 1'b0;
        have   = 1'b0;
        tgt    = 0;
        if (m_phase == 0) begin
            if (m_pend) begin
                tgt  = 3;
                have = 1'b1;
            end else if (q.size() > 0) begin
                tgt  = q[0];
                have = 1'b1;
            end
            if (have && exe_ready_i[tgt]) begin
                m_phase     = 1;
                m_grant     = tgt;
                m_from_grav = m_pend;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_cnt   = 0;
            if (m_from_grav) clear = 1'b1;
            else             void'(q.pop_front());
        end else begin
            m_cnt++;
            if (exe_ready_i[m_grant]) begin
                m_phase = 0;
            end else if (m_cnt == timeout_p) begin
                m_phase = 0;
                m_err   = 1'b1;
            end
        end
        if (accept) q.push_back(int'(cmd_i));
        if (grav_en) begin
            if (tick_i)     m_pend = 1'b1;
            else if (clear) m_pend = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare every output
    task automatic step();
        @(posedge clk_i);
        if (reset_i) model_reset();
        else         model_edge();
        #1;
        check("exe_v", 32'(exe_v_o), (m_phase == 1) ? (32'd1 << m_grant) : 32'd0);
        check("busy", 32'(busy_o), 32'(m_phase != 0));
        check("cmd_ready", 32'(cmd_ready_o), 32'(q.size() < 2));
        check("err", 32'(err_o), 32'(m_err));
        check("mm_x", 32'(mm_addr_r_x_o), 32'(exe_mm_x_i[m_grant]));
        check("mm_y", 32'(mm_addr_r_y_o), 32'(exe_mm_y_i[m_grant]));
        check("rom", 32'(rom_read_addr_o), 32'(exe_rom_addr_i[m_grant]));
        if (exe_v_o != 4'd0) pulses.push_back(exe_v_o);
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        cmd_v_i     = 1'b0;
        tick_i      = 1'b0;
        exe_ready_i = 4'hF;
        step();
        step();
        check("reset_exe_v", 32'(exe_v_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("reset_err", 32'(err_o), 32'd0);
        reset_i = 1'b0;
        pulses.delete();
    endtask

    task automatic wait_pulse(input string name, input logic [3:0] pat);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (exe_v_o == pat) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Expected pulse list packed four bits per pulse, first pulse in the low nibble
    task automatic check_pulses(input string name, input int n, input logic [15:0] exp);
        check(name, 32'(pulses.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < pulses.size()) check(name, 32'(pulses[i]), 32'(exp[4*i +: 4]));
        end
    endtask

    typedef struct {
        bit         v;
        cmd_e       cmd;
        logic [3:0] exp_v;
        bit         exp_busy;
        bit         exp_rdy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy_n;
        bit  done;
        bit  acc;
        checks         = 0;
        errors         = 0;
        reset_i        = 1'b1;
        cmd_v_i        = 1'b0;
        cmd_i          = eCmdRotate;
        tick_i         = 1'b0;
        exe_ready_i    = 4'hF;
        exe_mm_x_i     = {5'd7, 5'd5, 5'd3, 5'd1};
        exe_mm_y_i     = {6'd40, 6'd30, 6'd20, 6'd10};
        exe_rom_addr_i = {5'd19, 5'd18, 5'd17, 5'd16};
        model_reset();

        // Single rotate, then a fill/drain pattern with all executors ready
        tbl[0]  = '{1'b1, eCmdRotate, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, eCmdRotate, 4'h1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, eCmdRotate, 4'h0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, eCmdRotate, 4'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, eCmdLeft,   4'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, eCmdRight,  4'h2, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, eCmdDown,   4'h0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, eCmdDown,   4'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, eCmdRotate, 4'h4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, eCmdRotate, 4'h0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, eCmdRotate, 4'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, eCmdRotate, 4'h8, 1'b1, 1'b1};
        tbl[12] = '{1'b0, eCmdRotate, 4'h0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, eCmdRotate, 4'h0, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cmd_v_i = tbl[i].v;
            cmd_i   = tbl[i].cmd;
            step();
            check("tbl_exe_v", 32'(exe_v_o), 32'(tbl[i].exp_v));
            check("tbl_busy", 32'(busy_o), 32'(tbl[i].exp_busy));
            check("tbl_cmd_ready", 32'(cmd_ready_o), 32'(tbl[i].exp_rdy));
        end
        cmd_v_i = 1'b0;

        // Back-to-back pushes while executors are busy: third push held, order kept
        do_reset();
        exe_ready_i = 4'h0;
        cmd_v_i     = 1'b1;
        cmd_i       = eCmdLeft;
        step();
        cmd_i = eCmdRight;
        step();
        check("full_after_two", 32'(cmd_ready_o), 32'd0);
        cmd_i = eCmdDown;
        for (int i = 0; i < 3; i++) begin
            step();
            check("third_held", 32'(cmd_ready_o), 32'd0);
        end
        exe_ready_i = 4'hF;
        for (int i = 0; i < 30; i++) begin
            acc = cmd_v_i && cmd_ready_o;
            step();
            if (acc) cmd_v_i = 1'b0;
        end
        check_pulses("order_lrd", 3, 16'h0842);

        // Tick together with a rotate push
        do_reset();
        cmd_v_i = 1'b1;
        cmd_i   = eCmdRotate;
        tick_i  = 1'b1;
        step();
        cmd_v_i = 1'b0;
        tick_i  = 1'b0;
        repeat (20) step();
        if (grav_en) check_pulses("tick_with_push", 2, 16'h0018);
        else         check_pulses("tick_with_push", 1, 16'h0001);

        // Three ticks during one busy period coalesce
        do_reset();
        cmd_v_i = 1'b1;
        cmd_i   = eCmdRotate;
        step();
        cmd_v_i = 1'b0;
        wait_pulse("issue_before_ticks", 4'h1);
        exe_ready_i = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
            step();
        end
        exe_ready_i = 4'hF;
        repeat (20) step();
        if (grav_en) check_pulses("ticks_coalesce", 2, 16'h0081);
        else         check_pulses("ticks_coalesce", 1, 16'h0001);

        // Executor never finishes: timeout after 32 busy cycles, sticky error
        do_reset();
        cmd_v_i = 1'b1;
        cmd_i   = eCmdRotate;
        step();
        cmd_v_i = 1'b0;
        wait_pulse("issue_before_timeout", 4'h1);
        exe_ready_i = 4'b1110;
        busy_n      = 1;
        done        = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (busy_o) busy_n++;
            else        done = 1'b1;
        end
        check("timeout_busy_cycles", 32'(busy_n), 32'd33);
        check("timeout_err_set", 32'(err_o), 32'd1);
        exe_ready_i = 4'hF;
        repeat (5) step();
        check("timeout_err_sticky", 32'(err_o), 32'd1);

        // Shared-port mux on grant 2, then reset mid-busy discards everything
        do_reset();
        cmd_v_i = 1'b1;
        cmd_i   = eCmdRight;
        step();
        cmd_v_i = 1'b0;
        wait_pulse("issue_right", 4'h4);
        exe_ready_i = 4'h0;
        cmd_v_i     = 1'b1;
        cmd_i       = eCmdLeft;
        step();
        step();
        cmd_v_i = 1'b0;
        check("grant2_mm_x", 32'(mm_addr_r_x_o), 32'd5);
        check("grant2_busy", 32'(busy_o), 32'd1);
        check("grant2_fifo_full", 32'(cmd_ready_o), 32'd0);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy_o), 32'd0);
        check("async_reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("async_reset_exe_v", 32'(exe_v_o), 32'd0);
        check("async_reset_mm_x", 32'(mm_addr_r_x_o), 32'd1);
        model_reset();
        step();
        reset_i     = 1'b0;
        exe_ready_i = 4'hF;
        pulses.delete();
        repeat (5) step();
        check("queue_discarded", 32'(pulses.size()), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cmd_v_i = ($urandom_range(0, 99) < 60);
            cmd_i   = cmd_e'($urandom_range(0, 3));
            tick_i  = ($urandom_range(0, 99) < 10);
            for (int i = 0; i < 4; i++) begin
                exe_ready_i[i]    = ($urandom_range(0, 99) < 70);
                exe_mm_x_i[i]     = 5'($urandom);
                exe_mm_y_i[i]     = 6'($urandom);
                exe_rom_addr_i[i] = 5'($urandom);
            end
            reset_i = ((n % 700) == 699);
            step();
        end
        reset_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter width_p, default 16, playfield width in cells.
REQ-002 Parameter height_p, default 32, playfield height in cells.
REQ-003 Parameter timeout_p, default 32, the maximum number of cycles an executor may stay busy; legal range 4..63.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port cmd_v_i, input, 1 bit: user command valid.
REQ-007 Port cmd_i, input, cmd_e: user command (eCmdRotate, eCmdLeft, eCmdRight, eCmdDown).
REQ-008 Port cmd_ready_o, output, 1 bit: the command queue can accept a command.
REQ-009 Port tick_i, input, 1 bit: gravity tick pulse.
REQ-010 Port exe_v_o, output, 4 bits: one-hot start pulse per executor, index = cmd_e value.
REQ-011 Port exe_ready_i, input, 4 bits: per-executor ready_o.
REQ-012 Port exe_mm_x_i, input, [3:0][$clog2(width_p):0]: per-executor matrix-memory read x address.
REQ-013 Port exe_mm_y_i, input, [3:0][$clog2(height_p):0]: per-executor matrix-memory read y address.
REQ-014 Port exe_rom_addr_i, input, [3:0][4:0]: per-executor ROM read address.
REQ-015 Ports mm_addr_r_x_o, mm_addr_r_y_o and rom_read_addr_o, outputs: the shared-port addresses of the granted executor.
REQ-016 Port busy_o, output, 1 bit: the scheduler is not in eIDLE.
REQ-017 Port err_o, output, 1 bit: sticky executor-timeout flag.

Function
REQ-018 User commands SHALL enter a 2-entry FIFO when cmd_v_i && cmd_ready_o, with cmd_ready_o = !full; there is no bypass path, so the earliest start pulse is the cycle after acceptance.
REQ-019 tick_i SHALL set gravity_pend_r; ticks arriving while it is already set coalesce into the one pending request.
REQ-020 If tick_i coincides with the dispatch that clears gravity_pend_r, the set SHALL win.
REQ-021 FSM states and transitions SHALL be:
- eIDLE -> eIssue when a request exists.
- eIssue -> eBusy unconditionally.
- eBusy -> eIDLE on exe_ready_i[grant_r], or on timeout.
REQ-022 Request selection in eIDLE SHALL give gravity_pend_r priority over the FIFO head; a gravity request maps to index eCmdDown.
REQ-023 In eIDLE, a request whose target exe_ready_i bit is low SHALL stay pending, with no skip to other requests.
REQ-024 In eIssue, exe_v_o[grant_r] SHALL be high for exactly one cycle and all other bits SHALL be low; the FIFO pop or gravity clear happens in this cycle.
REQ-025 grant_r SHALL be loaded on eIDLE -> eIssue and hold until the next such load.
REQ-026 The shared-port outputs SHALL equal exe_*_i[grant_r] combinationally in every state.
REQ-027 A 6-bit counter SHALL count eBusy cycles; when it reaches timeout_p, the FSM returns to eIDLE and err_o is set, staying set until reset.
REQ-028 FIFO push and pop in the same cycle SHALL be legal when the FIFO is non-empty, and occupancy is then unchanged.

Reset
REQ-029 While reset_i is high, the FSM SHALL be in eIDLE and the FIFO empty; gravity_pend_r, grant_r (0), the counter and err_o are 0.
REQ-030 Output values in reset: exe_v_o=0, cmd_ready_o=1, busy_o=0.
REQ-031 Reset asserted mid-operation SHALL abandon the in-flight command and discard the queued commands.

Configuration
REQ-032 Macro CMD_SCHEDULER_GRAVITY_EN: when defined, REQ-019, REQ-020 and REQ-022 apply.
REQ-033 When CMD_SCHEDULER_GRAVITY_EN is undefined, tick_i is ignored, gravity_pend_r is constant 0, and only FIFO commands are dispatched.

Structure
REQ-034 Package tetris SHALL hold the cmd_e enum (2 bits: rotate=0, left=1, right=2, down=3) and the sched_state_e enum.
REQ-035 The FIFO SHALL be a sub-module, cmd_fifo, with depth 2 and width cmd_e.

Verification
REQ-036 Reset, then push eCmdRotate while exe_ready_i=4'hF -> exe_v_o=4'b0001 two cycles after the push, and busy_o for at least 2 cycles.
REQ-037 Push eCmdLeft, eCmdRight, eCmdDown back-to-back while executors are busy -> cmd_ready_o=0 after the second push; the third push is held, and the commands are dispatched in order 1, 2, 3.
REQ-038 tick_i in the same cycle as a push of eCmdRotate -> exe_v_o=4'b1000 first, then 4'b0001.
REQ-039 Three ticks during one busy period -> exactly one further eCmdDown dispatch.
REQ-040 Hold exe_ready_i[0]=0 after issuing a rotate -> return to eIDLE after 32 eBusy cycles, with err_o=1 held until reset.
REQ-041 grant_r=2 with exe_mm_x_i[2]=5 -> mm_addr_r_x_o=5; assert reset_i mid-eBusy -> busy_o=0 and cmd_ready_o=1 immediately.
